// File: rtl/ram_copy_pkg.sv
// rtl/ram_copy_pkg.sv - shared types and word-geometry constants for ram_copy_engine
//
// Purpose: FSM state and command-mode encodings, plus helpers that derive
// the bytes-per-word and the number of byte-address bits below a word
// boundary from a data width.
// Ports: none (package).

package ram_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
  localparam int WORD_LSB_BITS      = $clog2(BYTES_PER_WORD);

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int word_lsb_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - word-granular RAM fill/copy engine on a spare RAM port
//
// Purpose: on a start strobe, fills a destination window with a pattern or
// copies a source window to a destination window, one word at a time, over
// a byte-addressed RAM port with a one-cycle registered read.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, mode_i         command strobe (IDLE only), 0 = copy / 1 = fill
//   src_addr_i, dst_addr_i  word-aligned byte addresses
//   len_i, fill_data_i      word count, fill pattern
//   busy_o, done_o, err_o   status; done_o/err_o are one-cycle pulses
//   words_done_o            words written for the current/last command
//   ram_*                   RAM initiator port (en/addr/wdata/we/be, rdata)

module ram_copy_engine
  import ram_copy_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic [DATA_WIDTH-1:0]   fill_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [LEN_WIDTH-1:0]    words_done_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);

  // A mask rather than a slice keeps the alignment test legal even when a
  // word is a single byte (no low address bits to check).
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BPW);

  state_t                  r_state;
  state_t                  w_next_state;
  mode_t                   r_mode;
  logic [ADDR_WIDTH-1:0]   r_src;
  logic [ADDR_WIDTH-1:0]   r_dst;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [DATA_WIDTH-1:0]   r_fill;
  logic                    r_err;
  logic [LEN_WIDTH-1:0]    r_words;

  logic                    w_src_misaligned;
  logic                    w_dst_misaligned;
  logic                    w_cmd_misaligned;
  logic                    w_len_zero;
  logic                    w_accept;
  logic                    w_last;

  assign w_src_misaligned = |(src_addr_i & ALIGN_MASK);
  assign w_dst_misaligned = |(dst_addr_i & ALIGN_MASK);
  // Fill never reads, so only the destination has to be aligned.
  assign w_cmd_misaligned = mode_i ? w_dst_misaligned
                                   : (w_src_misaligned | w_dst_misaligned);
  assign w_len_zero       = (len_i == '0);
  assign w_accept         = (r_state == IDLE) && start_i;
  assign w_last           = ((r_words + LEN_WIDTH'(1)) == r_len);
  assign words_done_o     = r_words;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode  <= MODE_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_err   <= 1'b0;
      r_words <= '0;
    end else if (w_accept) begin
      r_mode  <= mode_t'(mode_i);
      r_src   <= src_addr_i;
      r_dst   <= dst_addr_i;
      r_len   <= len_i;
      r_fill  <= fill_data_i;
      // An empty command is not an error even if its addresses are odd.
      r_err   <= !w_len_zero && w_cmd_misaligned;
      r_words <= '0;
    end else if (r_state == WR) begin
      // Address wrap at the top of the RAM is intentional.
      r_words <= r_words + LEN_WIDTH'(1);
      r_src   <= r_src + ADDR_STEP;
      r_dst   <= r_dst + ADDR_STEP;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_be_o     = '0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;

    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (w_len_zero || w_cmd_misaligned) begin
            w_next_state = DONE;
          end else if (mode_i) begin
            w_next_state = WR;
          end else begin
            w_next_state = RD;
          end
        end
      end

      RD: begin
        ram_en_o     = 1'b1;
        ram_addr_o   = r_src;
        w_next_state = WR;
      end

      WR: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_be_o   = '1;
        ram_addr_o = r_dst;
        // Copy data is the word read in the preceding RD cycle.
        ram_wdata_o = (r_mode == MODE_FILL) ? r_fill : ram_rdata_i;
        if (w_last) begin
          w_next_state = DONE;
        end else if (r_mode == MODE_FILL) begin
          w_next_state = WR;
        end else begin
          w_next_state = RD;
        end
      end

      DONE: begin
        done_o       = 1'b1;
        err_o        = r_err;
        w_next_state = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule
